// File: rtl/des_pkg.sv
// Shared constants, tables and helpers for the DES key schedule and round engine.
package des_pkg;

    localparam int DES_ROUNDS = 16;
    localparam int HALF_W     = 28;
    localparam int SUBKEY_W   = 48;

    // Per-delivery-index rotate amounts; decrypt walks the encrypt schedule backwards.
    localparam logic [1:0] LSHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };
    localparam logic [1:0] RSHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Permutation tables in standard DES numbering (bit 1 = MSB).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } des_state_e;

    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] n);
        logic [HALF_W-1:0] r;
        case (n)
            2'd0:    r = x;
            2'd1:    r = {x[26:0], x[27]};
            2'd2:    r = {x[25:0], x[27:26]};
            default: r = {x[24:0], x[27:25]};
        endcase
        return r;
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input logic [1:0] n);
        logic [HALF_W-1:0] r;
        case (n)
            2'd0:    r = x;
            2'd1:    r = {x[0], x[27:1]};
            2'd2:    r = {x[1:0], x[27:2]};
            default: r = {x[2:0], x[27:3]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pc1.sv
// DES permuted choice 1: 64-bit key to 56-bit C||D, parity bits dropped.
module des_pc1
    import des_pkg::*;
(
    input  logic [63:0] key,
    output logic [55:0] pc1
);

    // DES bit n lives at key[64-n]; output bit 1 lands at pc1[55].
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1[55-i] = key[64-PC1_TAB[i]];
    end

    logic unused_parity;
    assign unused_parity = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

endmodule

// File: rtl/des_pc2.sv
// DES permuted choice 2: 56-bit C||D to 48-bit round subkey (bit 47 = PC2 bit 1).
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0]         cd,
    output logic [SUBKEY_W-1:0] subkey
);

    for (genvar j = 0; j < SUBKEY_W; j++) begin : g_pc2
        assign subkey[SUBKEY_W-1-j] = cd[56-PC2_TAB[j]];
    end

    // CD bits 9,18,22,25,35,38,43,54 are not selected by PC2.
    logic unused_cd;
    assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31],
                         cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: one PC2 subkey per round over valid/ready,
// K1..K16 for encrypt or K16..K1 for decrypt.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; key and decrypt sampled here only
//   S_ROUND | presenting subkey round_idx, advancing C/D on each accept
//   S_DONE  | one-cycle done pulse after the last subkey is accepted
module des_key_scheduler
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = DES_ROUNDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                decrypt,
    input  logic [63:0]         key,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic [3:0]          round_idx,
    output logic                busy,
    output logic                done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    des_state_e         state;
    logic [HALF_W-1:0]  c_q;
    logic [HALF_W-1:0]  d_q;
    logic               dec_q;
    logic [55:0]        pc1_w;
    logic [HALF_W-1:0]  pc1_c;
    logic [HALF_W-1:0]  pc1_d;
    logic [3:0]         next_idx;
    logic [1:0]         shamt;

    des_pc1 u_pc1 (
        .key (key),
        .pc1 (pc1_w)
    );

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (subkey)
    );

    assign pc1_c    = pc1_w[55:28];
    assign pc1_d    = pc1_w[27:0];
    assign next_idx = round_idx + 4'd1;

    // Amount applied when moving from the current subkey to the next one.
    always_comb begin
        shamt = 2'd0;
        if (dec_q) begin
            shamt = RSHIFT[next_idx];
        end else begin
            shamt = LSHIFT[next_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            c_q          <= '0;
            d_q          <= '0;
            dec_q        <= 1'b0;
            round_idx    <= '0;
            subkey_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dec_q        <= decrypt;
                        // Unrotated PC1 already equals C16/D16 (total shift is 28).
                        if (decrypt) begin
                            c_q <= pc1_c;
                            d_q <= pc1_d;
                        end else begin
                            c_q <= rotl28(pc1_c, LSHIFT[0]);
                            d_q <= rotl28(pc1_d, LSHIFT[0]);
                        end
                        round_idx    <= '0;
                        subkey_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= S_ROUND;
                    end
                end

                S_ROUND: begin
                    if (subkey_ready) begin
                        if (round_idx == LAST_IDX) begin
                            subkey_valid <= 1'b0;
                            done         <= 1'b1;
                            round_idx    <= '0;
                            state        <= S_DONE;
                        end else begin
                            if (dec_q) begin
                                c_q <= rotr28(c_q, shamt);
                                d_q <= rotr28(d_q, shamt);
                            end else begin
                                c_q <= rotl28(c_q, shamt);
                                d_q <= rotl28(d_q, shamt);
                            end
                            round_idx <= next_idx;
                        end
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    subkey_valid <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    round_idx    <= '0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule
